// File: rtl/fp_sigmul_iter.sv
// Iterative radix-4 Booth significand multiplier with carry-save accumulation and a final resolve add.
// Optional early termination on an all-zero multiplier tail: define FP_SIGMUL_EARLY_TERM_EN.
module fp_sigmul_iter #(
  parameter int unsigned sig_width = 23
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               enable,
  input  logic               start,
  input  logic [sig_width:0] a,
  input  logic [sig_width:0] b,
  output logic               busy,
  output logic               done,
  output logic [sig_width:0] product,
  output logic               norm_shift,
  output logic               guard_bit,
  output logic               round_bit,
  output logic               sticky_bit
);

  localparam int unsigned DIGITS = (sig_width + 3) / 2;
  localparam int unsigned AW     = 2 * sig_width + 4;
  localparam int unsigned MRW    = sig_width + 3;
  localparam int unsigned PW     = 2 * sig_width + 2;
  localparam int unsigned CW     = $clog2(DIGITS + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ITER    = 2'd1;
  localparam logic [1:0] S_RESOLVE = 2'd2;

  logic [1:0]       state;
  logic [AW-1:0]    md, sum_q, carry_q;
  logic [MRW-1:0]   mr;
  logic [CW-1:0]    cnt;

  logic [AW-1:0]    pp, maj, sum_d, carry_d;
  logic             neg;
  logic [MRW-1:0]   mr_next;
  logic             last_digit;
  logic [PW-1:0]    p;
  logic             ns_d, g_d, r_d, s_d;
  logic [sig_width:0] prod_d;

  assign busy = (state == S_ITER) || (state == S_RESOLVE);

  // Negative digits use the one's complement here; the +1 rides in carry bit 0,
  // which is always free because the CSA carry vector is shifted left.
  always_comb begin
    pp  = '0;
    neg = 1'b0;
    case (mr[2:0])
      3'b001, 3'b010: pp = md;
      3'b011:         pp = md << 1;
      3'b100: begin
        pp  = ~(md << 1);
        neg = 1'b1;
      end
      3'b101, 3'b110: begin
        pp  = ~md;
        neg = 1'b1;
      end
      default: pp = '0;
    endcase
    maj     = (sum_q & carry_q) | (sum_q & pp) | (carry_q & pp);
    sum_d   = sum_q ^ carry_q ^ pp;
    carry_d = {maj[AW-2:0], neg};
    mr_next = mr >> 2;
  end

`ifdef FP_SIGMUL_EARLY_TERM_EN
  assign last_digit = (cnt == CW'(DIGITS - 1)) || (mr_next == '0);
`else
  assign last_digit = (cnt == CW'(DIGITS - 1));
`endif

  always_comb begin
    p    = sum_q[PW-1:0] + carry_q[PW-1:0];
    ns_d = p[PW-1];
    if (ns_d) begin
      prod_d = p[PW-1 -: sig_width+1];
      g_d    = p[sig_width];
      r_d    = p[sig_width-1];
      s_d    = |p[sig_width-2:0];
    end else begin
      prod_d = p[PW-2 -: sig_width+1];
      g_d    = p[sig_width-1];
      r_d    = p[sig_width-2];
      s_d    = |p[sig_width-3:0];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      md         <= '0;
      mr         <= '0;
      sum_q      <= '0;
      carry_q    <= '0;
      cnt        <= '0;
      done       <= 1'b0;
      product    <= '0;
      norm_shift <= 1'b0;
      guard_bit  <= 1'b0;
      round_bit  <= 1'b0;
      sticky_bit <= 1'b0;
    end else if (enable) begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            md      <= AW'(a);
            mr      <= {1'b0, b, 1'b0};
            sum_q   <= '0;
            carry_q <= '0;
            cnt     <= '0;
            state   <= S_ITER;
          end
        end
        S_ITER: begin
          sum_q   <= sum_d;
          carry_q <= carry_d;
          md      <= md << 2;
          mr      <= mr_next;
          cnt     <= cnt + CW'(1);
          if (last_digit) state <= S_RESOLVE;
        end
        S_RESOLVE: begin
          product    <= prod_d;
          norm_shift <= ns_d;
          guard_bit  <= g_d;
          round_bit  <= r_d;
          sticky_bit <= s_d;
          done       <= 1'b1;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_sigmul_iter.sv
// Scoreboard bench for fp_sigmul_iter: single-precision directed vectors plus half-precision random pairs.
module tb_fp_sigmul_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn, enable;

  logic        s_start, s_busy, s_done, s_ns, s_g, s_r, s_s;
  logic [23:0] s_a, s_b, s_prod;
  logic        h_start, h_busy, h_done, h_ns, h_g, h_r, h_s;
  logic [10:0] h_a, h_b, h_prod;

  fp_sigmul_iter #(.sig_width(23)) u_s (
    .clk(clk), .resetn(resetn), .enable(enable), .start(s_start), .a(s_a), .b(s_b),
    .busy(s_busy), .done(s_done), .product(s_prod), .norm_shift(s_ns),
    .guard_bit(s_g), .round_bit(s_r), .sticky_bit(s_s)
  );

  fp_sigmul_iter #(.sig_width(10)) u_h (
    .clk(clk), .resetn(resetn), .enable(enable), .start(h_start), .a(h_a), .b(h_b),
    .busy(h_busy), .done(h_done), .product(h_prod), .norm_shift(h_ns),
    .guard_bit(h_g), .round_bit(h_r), .sticky_bit(h_s)
  );

  typedef struct {
    logic [23:0] prod;
    logic        ns, g, r, s;
    int unsigned cyc;
    string       name;
  } exp_t;

  exp_t s_q[$];
  exp_t h_q[$];
  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Cycle of done relative to accept: one edge per consumed digit plus the resolve edge.
  function automatic int unsigned lat(input int unsigned sw, input logic [23:0] b);
    int unsigned d  = (sw + 3) / 2;
    int unsigned kz = d;
    logic [63:0] m  = 64'(b) << 1;
    for (int unsigned k = 1; k <= d; k++) begin
      if ((m >> (2 * k)) == 64'd0) begin
        kz = k;
        break;
      end
    end
`ifdef FP_SIGMUL_EARLY_TERM_EN
    return kz + 1;
`else
    return (kz > d) ? kz : d + 1;
`endif
  endfunction

  function automatic exp_t model(input int unsigned sw, input logic [23:0] a, input logic [23:0] b);
    exp_t e;
    logic [63:0] p;
    int unsigned sh;
    p    = 64'(a) * 64'(b);
    e.ns = p[2*sw+1];
    sh   = e.ns ? sw + 1 : sw;
    e.prod = 24'(p >> sh);
    e.g  = p[sh-1];
    e.r  = p[sh-2];
    e.s  = (p & ((64'd1 << (sh - 2)) - 64'd1)) != 64'd0;
    e.cyc = 0;
    e.name = "";
    return e;
  endfunction

  logic s_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (s_done && !s_prev) begin
      if (s_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL s_unexpected_done actual=1 required=0 at cycle %0d", cyc);
      end else begin
        e = s_q.pop_front();
        chk({e.name, "_product"}, 64'(s_prod), 64'(e.prod));
        chk({e.name, "_norm_shift"}, 64'(s_ns), 64'(e.ns));
        chk({e.name, "_guard"}, 64'(s_g), 64'(e.g));
        chk({e.name, "_round"}, 64'(s_r), 64'(e.r));
        chk({e.name, "_sticky"}, 64'(s_s), 64'(e.s));
        chk({e.name, "_done_cycle"}, 64'(cyc), 64'(e.cyc));
      end
    end
    s_prev = s_done;
  end

  logic h_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (h_done && !h_prev) begin
      if (h_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL h_unexpected_done actual=1 required=0 at cycle %0d", cyc);
      end else begin
        e = h_q.pop_front();
        chk({e.name, "_product"}, 64'(h_prod), 64'(e.prod));
        chk({e.name, "_norm_shift"}, 64'(h_ns), 64'(e.ns));
        chk({e.name, "_guard"}, 64'(h_g), 64'(e.g));
        chk({e.name, "_round"}, 64'(h_r), 64'(e.r));
        chk({e.name, "_sticky"}, 64'(h_s), 64'(e.s));
        chk({e.name, "_done_cycle"}, 64'(cyc), 64'(e.cyc));
      end
    end
    h_prev = h_done;
  end

  task automatic issue_s(input logic [23:0] a, input logic [23:0] b, input logic [23:0] prod,
                         input logic ns, input logic g, input logic r, input logic s,
                         input int unsigned extra, input string nm);
    exp_t e;
    @(negedge clk);
    s_a = a;
    s_b = b;
    s_start = 1'b1;
    e.prod = prod; e.ns = ns; e.g = g; e.r = r; e.s = s;
    e.cyc  = cyc + 1 + lat(23, b) + extra;
    e.name = nm;
    s_q.push_back(e);
    @(negedge clk);
    s_start = 1'b0;
  endtask

  task automatic issue_h(input logic [10:0] a, input logic [10:0] b, input string nm);
    exp_t e;
    @(negedge clk);
    h_a = a;
    h_b = b;
    h_start = 1'b1;
    e = model(10, 24'(a), 24'(b));
    e.cyc  = cyc + 1 + lat(10, 24'(b));
    e.name = nm;
    h_q.push_back(e);
    @(negedge clk);
    h_start = 1'b0;
  endtask

  task automatic wait_done_s(input string nm);
    int n = 0;
    while (!s_done && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no_done required=done", nm);
    end
  endtask

  task automatic wait_done_h(input string nm);
    int n = 0;
    while (!h_done && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no_done required=done", nm);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int busy_cnt;
    resetn = 1'b0; enable = 1'b1;
    s_start = 1'b0; s_a = '0; s_b = '0;
    h_start = 1'b0; h_a = '0; h_b = '0;
    #12;
    chk("rst_busy", 64'(s_busy), 64'd0);
    chk("rst_done", 64'(s_done), 64'd0);
    chk("rst_product", 64'(s_prod), 64'd0);
    chk("rst_flags", 64'({s_ns, s_g, s_r, s_s}), 64'd0);
    chk("rst_h_busy", 64'(h_busy), 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    issue_s(24'h800000, 24'h800000, 24'h800000, 1'b0, 1'b0, 1'b0, 1'b0, 0, "one_x_one");
    wait_done_s("one_x_one");
    issue_s(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFE, 1'b1, 1'b0, 1'b0, 1'b1, 0, "max_sq");
    wait_done_s("max_sq");
    issue_s(24'hC00000, 24'hC00000, 24'h900000, 1'b1, 1'b0, 1'b0, 1'b0, 0, "c0_sq");
    wait_done_s("c0_sq");
    issue_s(24'hC00000, 24'hAAAAAB, 24'h800000, 1'b1, 1'b0, 1'b1, 1'b0, 0, "c0_x_aaab");
    wait_done_s("c0_x_aaab");
    issue_s(24'hFFFFFF, 24'h800000, 24'hFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 0, "just_below_2");
    wait_done_s("just_below_2");
    issue_s(24'hFFFFFF, 24'h000000, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 0, "zero_b");
    wait_done_s("zero_b");

    // enable low for 5 cycles mid-iteration, start pulsed while busy
    issue_s(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFE, 1'b1, 1'b0, 1'b0, 1'b1, 5, "stall");
    repeat (3) @(negedge clk);
    enable = 1'b0;
    s_start = 1'b1;
    s_a = 24'h123456;
    s_b = 24'h654321;
    repeat (5) @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    wait_done_s("stall");
    busy_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (s_busy) busy_cnt++;
    end
    chk("stall_no_restart", 64'(busy_cnt), 64'd0);

    // reset at cnt=6 aborts the operation
    issue_s(24'hC00000, 24'hAAAAAB, 24'h800000, 1'b1, 1'b0, 1'b1, 1'b0, 0, "aborted");
    repeat (6) @(negedge clk);
    resetn = 1'b0;
    s_q.delete();
    #1;
    chk("abort_busy", 64'(s_busy), 64'd0);
    chk("abort_done", 64'(s_done), 64'd0);
    chk("abort_product", 64'(s_prod), 64'd0);
    chk("abort_flags", 64'({s_ns, s_g, s_r, s_s}), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (20) @(negedge clk);
    issue_s(24'hC00000, 24'hC00000, 24'h900000, 1'b1, 1'b0, 1'b0, 1'b0, 0, "after_abort");
    wait_done_s("after_abort");

    issue_h(11'h400, 11'h400, "h_one");
    wait_done_h("h_one");
    issue_h(11'h7FF, 11'h7FF, "h_max");
    wait_done_h("h_max");
    for (int i = 0; i < 2000; i++) begin
      issue_h({1'b1, 10'($urandom)}, {1'b1, 10'($urandom)}, "h_rand");
      wait_done_h("h_rand");
    end

    repeat (5) @(negedge clk);
    chk("s_queue_drained", 64'(s_q.size()), 64'd0);
    chk("h_queue_drained", 64'(h_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
